// File: rtl/rc_dpdm_nrzi_sipo_if.sv
// Receive-side signal bundle for the USB D+/D- front end.
// The bench or upstream logic uses master; rc_dpdm_nrzi_sipo uses slave.
interface rc_dpdm_nrzi_sipo_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       bus_in;
    logic             enable;
    logic             abort;
    logic             receive_data;
    logic             receive_hshake;
    logic             sipo_en;
    logic             shift_left;
    logic             s_out;
    logic             got_sync;
    logic             start_rc_nrzi;
    logic             end_rc_nrzi;
    logic             EOP_error;
    logic             nrzi_out;
    logic             start_unstuffer;
    logic             end_unstuffer;
    logic [WIDTH-1:0] Q;

    modport master (
        output bus_in, enable, abort, receive_data, receive_hshake, sipo_en, shift_left,
        input  s_out, got_sync, start_rc_nrzi, end_rc_nrzi, EOP_error, nrzi_out,
               start_unstuffer, end_unstuffer, Q
    );

    modport slave (
        input  bus_in, enable, abort, receive_data, receive_hshake, sipo_en, shift_left,
        output s_out, got_sync, start_rc_nrzi, end_rc_nrzi, EOP_error, nrzi_out,
               start_unstuffer, end_unstuffer, Q
    );
endinterface

// File: rtl/rc_dpdm_nrzi_sipo.sv
// USB LS/FS receive front end: SYNC hunt, J/K level recovery, EOP checking,
// NRZI decode and serial-to-parallel shift register.
module rc_dpdm_nrzi_sipo #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    rc_dpdm_nrzi_sipo_if.slave rx
);
    typedef enum logic [2:0] {IDLE, HUNT, RECEIVE, EOP1, EOP2} state_t;

    localparam logic [1:0]  SYM_J    = 2'b10;
    localparam logic [1:0]  SYM_K    = 2'b01;
    localparam logic [1:0]  SYM_SE0  = 2'b00;
    localparam logic [15:0] SYNC_PAT = {SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K};

    state_t           state;
    logic [13:0]      hist;
    logic [15:0]      window;
    logic             line_lvl;
    logic             got_sync;
    logic             start_rc;
    logic             end_rc;
    logic             eop_err;
    logic             dec_active;
    logic             dec_prev;
    logic             nrzi_bit;
    logic [1:0]       start_dly;
    logic [1:0]       end_dly;
    logic [1:0]       sipo_dly;
    logic [WIDTH-1:0] shreg;

    // Seven stored symbols plus the one being sampled form the 8-symbol window.
    assign window = {hist, rx.bus_in};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            hist     <= '0;
            line_lvl <= 1'b0;
            got_sync <= 1'b0;
            start_rc <= 1'b0;
            end_rc   <= 1'b0;
            eop_err  <= 1'b0;
        end else if (rx.abort || rx.enable) begin
            state    <= IDLE;
            hist     <= '0;
            line_lvl <= 1'b0;
            got_sync <= 1'b0;
            start_rc <= 1'b0;
            end_rc   <= 1'b0;
            eop_err  <= 1'b0;
        end else begin
            hist     <= window[13:0];
            start_rc <= 1'b0;
            end_rc   <= 1'b0;
            eop_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx.receive_data || rx.receive_hshake) state <= HUNT;
                end
                HUNT: begin
                    if (window == SYNC_PAT) begin
                        state    <= RECEIVE;
                        got_sync <= 1'b1;
                        start_rc <= 1'b1;
                        line_lvl <= 1'b0;
                    end
                end
                RECEIVE: begin
                    case (rx.bus_in)
                        SYM_J:   line_lvl <= 1'b1;
                        SYM_K:   line_lvl <= 1'b0;
                        SYM_SE0: begin
                            state  <= EOP1;
                            end_rc <= 1'b1;
                        end
                        default: begin
                            state    <= IDLE;
                            got_sync <= 1'b0;
                            eop_err  <= 1'b1;
                        end
                    endcase
                end
                EOP1: begin
                    if (rx.bus_in == SYM_SE0) begin
                        state <= EOP2;
                    end else begin
                        state    <= IDLE;
                        got_sync <= 1'b0;
                        eop_err  <= 1'b1;
                    end
                end
                EOP2: begin
                    state    <= IDLE;
                    got_sync <= 1'b0;
                    eop_err  <= (rx.bus_in != SYM_J);
                end
                default: begin
                    state    <= IDLE;
                    got_sync <= 1'b0;
                end
            endcase
        end
    end

    // Decoder also stops on a framing error so it never runs on after an SE1 abort of the packet.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            dec_active <= 1'b0;
            dec_prev   <= 1'b0;
            nrzi_bit   <= 1'b0;
            start_dly  <= '0;
            end_dly    <= '0;
            sipo_dly   <= '0;
            shreg      <= '0;
        end else if (rx.abort || rx.enable) begin
            dec_active <= 1'b0;
            dec_prev   <= 1'b0;
            nrzi_bit   <= 1'b0;
            start_dly  <= '0;
            end_dly    <= '0;
            sipo_dly   <= '0;
        end else begin
            start_dly <= {start_dly[0], start_rc};
            end_dly   <= {end_dly[0], end_rc};
            sipo_dly  <= {sipo_dly[0], rx.sipo_en};
            if (start_rc) begin
                dec_active <= 1'b1;
                dec_prev   <= 1'b0;
                nrzi_bit   <= 1'b0;
            end else if (end_rc || eop_err) begin
                dec_active <= 1'b0;
                nrzi_bit   <= 1'b0;
            end else if (dec_active) begin
                nrzi_bit <= (line_lvl == dec_prev);
                dec_prev <= line_lvl;
            end else begin
                nrzi_bit <= 1'b0;
            end
            if (sipo_dly[1]) begin
                shreg <= rx.shift_left ? {shreg[WIDTH-2:0], nrzi_bit}
                                       : {nrzi_bit, shreg[WIDTH-1:1]};
            end
        end
    end

    assign rx.s_out           = line_lvl;
    assign rx.got_sync        = got_sync;
    assign rx.start_rc_nrzi   = start_rc;
    assign rx.end_rc_nrzi     = end_rc;
    assign rx.EOP_error       = eop_err;
    assign rx.nrzi_out        = nrzi_bit;
    assign rx.start_unstuffer = start_dly[1];
    assign rx.end_unstuffer   = end_dly[1];
    assign rx.Q               = shreg;
endmodule

// File: tb/tb_rc_dpdm_nrzi_sipo.sv
// Scoreboard bench for rc_dpdm_nrzi_sipo: expectations are scheduled against an
// edge number when stimulus is driven and checked at the falling edge after it.
module tb_rc_dpdm_nrzi_sipo;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    typedef enum int unsigned {
        SIG_S_OUT, SIG_GOT_SYNC, SIG_START_RC, SIG_END_RC, SIG_ERR,
        SIG_NRZI, SIG_START_UN, SIG_END_UN, SIG_Q
    } sig_t;

    typedef struct {
        int unsigned cyc;
        sig_t        sig;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned edges = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t        sb[$];

    rc_dpdm_nrzi_sipo_if #(.WIDTH(8)) ifc ();

    rc_dpdm_nrzi_sipo #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] probe(sig_t sig);
        case (sig)
            SIG_S_OUT:    return 16'(ifc.s_out);
            SIG_GOT_SYNC: return 16'(ifc.got_sync);
            SIG_START_RC: return 16'(ifc.start_rc_nrzi);
            SIG_END_RC:   return 16'(ifc.end_rc_nrzi);
            SIG_ERR:      return 16'(ifc.EOP_error);
            SIG_NRZI:     return 16'(ifc.nrzi_out);
            SIG_START_UN: return 16'(ifc.start_unstuffer);
            SIG_END_UN:   return 16'(ifc.end_unstuffer);
            default:      return 16'(ifc.Q);
        endcase
    endfunction

    function automatic void expect_at(int unsigned cyc, sig_t sig, logic [15:0] val);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == edges) begin
                check($sformatf("%s@%0d", sb[i].sig.name(), edges), probe(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step(input logic [1:0] sym, input logic sipo);
        ifc.bus_in  = sym;
        ifc.sipo_en = sipo;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync(output int unsigned e, input logic synced);
        logic [1:0] pat [8];
        pat = '{SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K};
        e = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                e = edges + 1;
                expect_at(e, SIG_GOT_SYNC, 16'(synced));
                expect_at(e, SIG_START_RC, 16'(synced));
                expect_at(e + 1, SIG_GOT_SYNC, 16'(synced));
                expect_at(e + 1, SIG_START_RC, 16'd0);
            end
            step(pat[i], 1'b0);
        end
    endtask

    task automatic run_handshake(input logic left, input logic [7:0] want_q);
        logic [1:0]  data [8];
        int unsigned e;
        int unsigned t;
        logic        prev;
        logic        lvl;
        data = '{SYM_J, SYM_J, SYM_K, SYM_J, SYM_J, SYM_K, SYM_K, SYM_K};
        ifc.shift_left     = left;
        ifc.receive_hshake = 1'b1;
        step(SYM_J, 1'b0);
        send_sync(e, 1'b1);
        ifc.receive_hshake = 1'b0;
        expect_at(e + 2, SIG_START_UN, 16'd1);
        expect_at(e + 3, SIG_START_UN, 16'd0);
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t   = edges + 1;
            lvl = (data[i] == SYM_J);
            expect_at(t, SIG_S_OUT, 16'(lvl));
            expect_at(t + 1, SIG_NRZI, 16'(lvl == prev));
            expect_at(t, SIG_ERR, 16'd0);
            prev = lvl;
            step(data[i], 1'b1);
        end
        expect_at(e + 10, SIG_Q, 16'(want_q));
        t = edges + 1;
        expect_at(t, SIG_END_RC, 16'd1);
        expect_at(t + 1, SIG_END_RC, 16'd0);
        expect_at(t + 2, SIG_END_UN, 16'd1);
        expect_at(t + 3, SIG_END_UN, 16'd0);
        expect_at(t + 1, SIG_NRZI, 16'd0);
        expect_at(t + 1, SIG_GOT_SYNC, 16'd1);
        expect_at(t + 2, SIG_GOT_SYNC, 16'd0);
        expect_at(t + 3, SIG_Q, 16'(want_q));
        for (int k = 0; k < 4; k++) expect_at(t + k, SIG_ERR, 16'd0);
        step(SYM_SE0, 1'b0);
        step(SYM_SE0, 1'b0);
        step(SYM_J, 1'b0);
        step(SYM_J, 1'b0);
    endtask

    initial begin
        int unsigned e;
        int unsigned t;
        rst_n              = 1'b1;
        ifc.bus_in         = SYM_J;
        ifc.enable         = 1'b0;
        ifc.abort          = 1'b0;
        ifc.receive_data   = 1'b0;
        ifc.receive_hshake = 1'b0;
        ifc.sipo_en        = 1'b0;
        ifc.shift_left     = 1'b1;

        step(SYM_J, 1'b0);
        t = edges + 1;
        for (int s = 0; s <= int'(SIG_Q); s++) expect_at(t, sig_t'(s), 16'd0);
        step(SYM_J, 1'b0);
        rst_n = 1'b0;
        step(SYM_J, 1'b0);

        run_handshake(1'b1, 8'b01001011);

        // SE0 then J: second EOP symbol missing
        ifc.receive_data = 1'b1;
        step(SYM_J, 1'b0);
        send_sync(e, 1'b1);
        ifc.receive_data = 1'b0;
        step(SYM_K, 1'b0);
        t = edges + 1;
        expect_at(t, SIG_END_RC, 16'd1);
        expect_at(t, SIG_ERR, 16'd0);
        expect_at(t + 1, SIG_ERR, 16'd1);
        expect_at(t + 2, SIG_ERR, 16'd0);
        expect_at(t + 1, SIG_GOT_SYNC, 16'd0);
        step(SYM_SE0, 1'b0);
        step(SYM_J, 1'b0);
        step(SYM_J, 1'b0);

        // Valid SYNC while unarmed, then while the local transmitter owns the bus
        step(SYM_J, 1'b0);
        send_sync(e, 1'b0);
        step(SYM_J, 1'b0);
        ifc.enable       = 1'b1;
        ifc.receive_data = 1'b1;
        step(SYM_J, 1'b0);
        send_sync(e, 1'b0);
        step(SYM_J, 1'b0);
        ifc.enable       = 1'b0;
        ifc.receive_data = 1'b0;
        step(SYM_J, 1'b0);

        // Abort in RECEIVE: back to IDLE, Q kept, later SE0 ignored
        ifc.receive_data = 1'b1;
        step(SYM_J, 1'b0);
        send_sync(e, 1'b1);
        ifc.receive_data = 1'b0;
        step(SYM_K, 1'b0);
        t = edges + 1;
        expect_at(t, SIG_S_OUT, 16'd1);
        step(SYM_J, 1'b0);
        t = edges + 1;
        expect_at(t, SIG_GOT_SYNC, 16'd0);
        expect_at(t, SIG_S_OUT, 16'd0);
        expect_at(t, SIG_NRZI, 16'd0);
        expect_at(t, SIG_Q, 16'h004B);
        expect_at(t + 1, SIG_END_RC, 16'd0);
        expect_at(t + 2, SIG_END_RC, 16'd0);
        expect_at(t + 3, SIG_END_UN, 16'd0);
        expect_at(t + 2, SIG_ERR, 16'd0);
        ifc.abort = 1'b1;
        step(SYM_J, 1'b0);
        ifc.abort = 1'b0;
        step(SYM_SE0, 1'b0);
        step(SYM_SE0, 1'b0);
        step(SYM_J, 1'b0);
        step(SYM_J, 1'b0);

        run_handshake(1'b0, 8'b11010010);

        // Reset two edges after SYNC: pending start_unstuffer and shift are dropped
        ifc.shift_left   = 1'b1;
        ifc.receive_data = 1'b1;
        step(SYM_J, 1'b0);
        send_sync(e, 1'b1);
        ifc.receive_data = 1'b0;
        step(SYM_K, 1'b1);
        t = edges + 1;
        for (int s = 0; s <= int'(SIG_Q); s++) expect_at(t, sig_t'(s), 16'd0);
        expect_at(t + 1, SIG_Q, 16'd0);
        expect_at(t + 1, SIG_GOT_SYNC, 16'd0);
        rst_n = 1'b1;
        step(SYM_K, 1'b1);
        rst_n = 1'b0;
        step(SYM_J, 1'b0);
        step(SYM_J, 1'b0);
        step(SYM_J, 1'b0);

        check("sb_drain", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
